// File: rtl/alu_serial_if.sv
// Operand/result handshake bundle for the bit-serial ALU.
interface alu_serial_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             zero;
   logic             ovf;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, cout, zero, ovf
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, cout, zero, ovf
   );
endinterface

// File: rtl/alu_serial.sv
// Slice-serial ALU: NOR/XOR/ADD/SUB over WIDTH bits, SLICE bits per clock, LSB slice first.
// Optional zero/overflow flags enabled by defining ALU_SERIAL_FLAGS_EN.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one slice computed per cycle, N = WIDTH/SLICE cycles
// DONE  | result held, out_valid high until out_ready
module alu_serial #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input logic          clk,
   input logic          rst_n,
   alu_serial_if.slave  bus
);
   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] OP_NOR = 2'b00;
   localparam logic [1:0] OP_XOR = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b11;

   if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_param
      $error("alu_serial: WIDTH must be >= 2 and divisible by SLICE");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt, seg_ext;
   logic [1:0]       op_q;
   logic             carry, cout_q;
   logic             in_ready_c, out_valid_c, accept, last_slice;
   logic [SLICE-1:0] a_seg, b_seg, seg;
   logic [SLICE:0]   sum;

   assign accept     = bus.in_valid && in_ready_c;
   assign last_slice = (cnt == CW'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (last_slice) state_nxt = DONE;
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operands shift right so the active slice always sits in the low bits.
   assign a_seg = a_q[SLICE-1:0];
   assign b_seg = b_q[SLICE-1:0];
   assign sum   = {1'b0, a_seg} + {1'b0, b_seg} + {{SLICE{1'b0}}, carry};

   always_comb begin
      case (op_q)
         OP_NOR:  seg = ~(a_seg | b_seg);
         OP_XOR:  seg = a_seg ^ b_seg;
         default: seg = sum[SLICE-1:0];
      endcase
   end

   always_comb begin
      seg_ext = '0;
      seg_ext[WIDTH-1 -: SLICE] = seg;
   end

   assign res_nxt = (res_q >> SLICE) | seg_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         carry  <= 1'b0;
         res_q  <= '0;
         cout_q <= 1'b0;
      end else if (accept) begin
         a_q   <= bus.a;
         b_q   <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
         op_q  <= bus.op;
         carry <= (bus.op == OP_SUB);
         cnt   <= '0;
      end else if (state == RUN) begin
         a_q   <= a_q >> SLICE;
         b_q   <= b_q >> SLICE;
         res_q <= res_nxt;
         carry <= op_q[1] & sum[SLICE];
         if (last_slice) begin
            cnt    <= '0;
            cout_q <= op_q[1] & sum[SLICE];
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

`ifdef ALU_SERIAL_FLAGS_EN
   logic zero_q, ovf_q;

   // b_seg is already inverted for SUB, so one same-sign test covers both ops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (state == RUN && last_slice) begin
         zero_q <= (res_nxt == '0);
         ovf_q  <= op_q[1] & (a_seg[SLICE-1] == b_seg[SLICE-1])
                           & (seg[SLICE-1] != a_seg[SLICE-1]);
      end
   end

   assign bus.zero = zero_q;
   assign bus.ovf  = ovf_q;
`else
   assign bus.zero = 1'b0;
   assign bus.ovf  = 1'b0;
`endif

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.result    = res_q;
   assign bus.cout      = cout_q;
endmodule
